lut_access_arbiter: RTL and testbench

LUT_ACCESS_ARBITER -- requirements
Module: lut_access_arbiter

---
 rtl/lut_access_arbiter.sv | 80 ++++++++
 tb/tb_lut_access_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lut_access_arbiter.sv
// Two-requester arbiter in front of one combinational lookup memory.
// It grants one request per cycle, alternates grants under contention, and returns each looked-up word one cycle later.
module lut_access_arbiter #(
   parameter int IN  = 9,
   parameter int OUT = 19
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   input  logic [IN-1:0]  req0_index,
   output logic           req0_ready,
   output logic           rsp0_valid,
   output logic [OUT-1:0] rsp0_data,
   input  logic           req1_valid,
   input  logic [IN-1:0]  req1_index,
   output logic           req1_ready,
   output logic           rsp1_valid,
   output logic [OUT-1:0] rsp1_data,
   output logic [IN-1:0]  mem_index,
   input  logic [OUT-1:0] mem_out
);

   logic          prio;
   logic          gnt0;
   logic          gnt1;
   logic          rsp0_valid_q;
   logic          rsp1_valid_q;
   logic [IN-1:0] index_q;
   logic [15:0]   grant_cnt;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (req0_valid && req1_valid) begin
            gnt0 = ~prio;
            gnt1 = prio;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // With no grant this cycle, the memory keeps seeing the last index it was given.
   assign mem_index = gnt1 ? req1_index : (gnt0 ? req0_index : index_q);

   // A reset in the cycle after a grant cancels the response that was pending.
   assign rsp0_valid = rsp0_valid_q & ~rst;
   assign rsp1_valid = rsp1_valid_q & ~rst;

   // NOTE: state registers use non-blocking assignments, so all of them update from the values of the same clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio         <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data    <= '0;
         rsp1_data    <= '0;
         index_q      <= '0;
         grant_cnt    <= '0;
      end else begin
         rsp0_valid_q <= gnt0;
         rsp1_valid_q <= gnt1;
         if (gnt0) rsp0_data <= mem_out;
         if (gnt1) rsp1_data <= mem_out;
         if (gnt0 || gnt1) begin
            index_q   <= mem_index;
            grant_cnt <= grant_cnt + 16'd1;
         end
         // Under contention, priority moves to the requester that lost this round.
         if (req0_valid && req1_valid) prio <= gnt0;
      end
   end

endmodule

// File: tb/tb_lut_access_arbiter.sv
// Testbench for lut_access_arbiter: directed vector table, hand-written corner sequences, and random traffic.
// Every cycle is also compared against a cycle-level model of the grant and response rules.
module tb_lut_access_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [8:0]  req0_index = '0, req1_index = '0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [18:0] rsp0_data, rsp1_data, mem_out;
   logic [8:0]  mem_index;
   logic [18:0] mem [512];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;
   assign mem_out = mem[mem_index];

   lut_access_arbiter #(.IN(9), .OUT(19)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_index(req0_index), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
      .req1_valid(req1_valid), .req1_index(req1_index), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
      .mem_index(mem_index), .mem_out(mem_out)
   );

   // Reference state, kept as plain spec-level quantities.
   bit          m_prio = 1'b0;
   bit          m_pv [2] = '{1'b0, 1'b0};
   logic [18:0] m_pd [2] = '{19'd0, 19'd0};
   logic [8:0]  m_last = '0;
   int          last_w = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at the falling edge, compare 1 time unit later, then advance the model.
   task automatic step(input bit r, input bit v0, input logic [8:0] i0,
                       input bit v1, input logic [8:0] i1);
      int          w;
      logic [8:0]  e_mi;
      @(negedge clk);
      rst = r; req0_valid = v0; req0_index = i0; req1_valid = v1; req1_index = i1;
      #1;
      w = -1;
      if (!r) begin
         if (v0 && v1) w = int'(m_prio);
         else if (v0)  w = 0;
         else if (v1)  w = 1;
      end
      e_mi = (w == 0) ? i0 : (w == 1) ? i1 : m_last;
      check("model_ready0", 32'(req0_ready), 32'(w == 0));
      check("model_ready1", 32'(req1_ready), 32'(w == 1));
      check("model_mem_index", 32'(mem_index), 32'(e_mi));
      check("model_rsp0_valid", 32'(rsp0_valid), 32'(m_pv[0] && !r));
      check("model_rsp1_valid", 32'(rsp1_valid), 32'(m_pv[1] && !r));
      check("model_rsp0_data", 32'(rsp0_data), 32'(m_pd[0]));
      check("model_rsp1_data", 32'(rsp1_data), 32'(m_pd[1]));
      last_w = w;
      if (r) begin
         m_prio = 1'b0; m_pv = '{1'b0, 1'b0}; m_pd = '{19'd0, 19'd0}; m_last = '0;
      end else begin
         m_pv[0] = (w == 0);
         m_pv[1] = (w == 1);
         if (w >= 0) begin
            m_pd[w] = mem[e_mi];
            m_last  = e_mi;
         end
         if (v0 && v1) m_prio = !m_prio;
      end
   endtask

   typedef struct {
      bit r; bit v0; logic [8:0] i0; bit v1; logic [8:0] i1;
      bit e_r0; bit e_r1; bit e_v0; bit e_v1;
      logic [18:0] e_d0; logic [18:0] e_d1; logic [8:0] e_mi;
   } vec_t;

   vec_t vecs [9];

   initial begin
      bit          h_v0, h_v1;
      logic [8:0]  h_i0, h_i1;

      for (int i = 0; i < 512; i++) mem[i] = 19'($urandom);
      mem[5]  = 19'h12345;
      mem[16] = 19'h0AAAA;
      mem[32] = 19'h05555;

      //          r  v0 i0      v1 i1      r0 r1 v0 v1 d0          d1          mi
      vecs[0] = '{0, 1, 9'h005, 0, 9'h000, 1, 0, 0, 0, 19'h00000, 19'h00000, 9'h005};
      vecs[1] = '{0, 0, 9'h000, 0, 9'h000, 0, 0, 1, 0, 19'h12345, 19'h00000, 9'h005};
      vecs[2] = '{1, 0, 9'h000, 0, 9'h000, 0, 0, 0, 0, 19'h12345, 19'h00000, 9'h005};
      vecs[3] = '{0, 1, 9'h010, 1, 9'h020, 1, 0, 0, 0, 19'h00000, 19'h00000, 9'h010};
      vecs[4] = '{0, 1, 9'h010, 1, 9'h020, 0, 1, 1, 0, 19'h0AAAA, 19'h00000, 9'h020};
      vecs[5] = '{0, 1, 9'h010, 1, 9'h020, 1, 0, 0, 1, 19'h0AAAA, 19'h05555, 9'h010};
      vecs[6] = '{0, 1, 9'h010, 1, 9'h020, 0, 1, 1, 0, 19'h0AAAA, 19'h05555, 9'h020};
      vecs[7] = '{0, 0, 9'h000, 0, 9'h000, 0, 0, 0, 1, 19'h0AAAA, 19'h05555, 9'h020};
      vecs[8] = '{0, 0, 9'h000, 0, 9'h000, 0, 0, 0, 0, 19'h0AAAA, 19'h05555, 9'h020};

      // Initial reset with no comparisons while DUT state is still unknown.
      repeat (2) @(posedge clk);

      // Directed table: single request, reset, then four contended cycles.
      for (int k = 0; k < 9; k++) begin
         step(vecs[k].r, vecs[k].v0, vecs[k].i0, vecs[k].v1, vecs[k].i1);
         check($sformatf("vec%0d_ready0", k), 32'(req0_ready), 32'(vecs[k].e_r0));
         check($sformatf("vec%0d_ready1", k), 32'(req1_ready), 32'(vecs[k].e_r1));
         check($sformatf("vec%0d_rsp0_valid", k), 32'(rsp0_valid), 32'(vecs[k].e_v0));
         check($sformatf("vec%0d_rsp1_valid", k), 32'(rsp1_valid), 32'(vecs[k].e_v1));
         check($sformatf("vec%0d_rsp0_data", k), 32'(rsp0_data), 32'(vecs[k].e_d0));
         check($sformatf("vec%0d_rsp1_data", k), 32'(rsp1_data), 32'(vecs[k].e_d1));
         check($sformatf("vec%0d_mem_index", k), 32'(mem_index), 32'(vecs[k].e_mi));
      end

      // Solo streaming on requester 1.
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         step(0, 0, 0, 1, 9'(k));
         check("solo_ready1", 32'(req1_ready), 32'd1);
         if (k > 0) begin
            check("solo_rsp1_valid", 32'(rsp1_valid), 32'd1);
            check("solo_rsp1_data", 32'(rsp1_data), 32'(mem[k-1]));
         end
      end
      step(0, 0, 0, 0, 0);
      check("solo_last_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check("solo_last_rsp1_data", 32'(rsp1_data), 32'(mem[7]));

      // Priority retention across uncontended cycles.
      step(1, 0, 0, 0, 0);
      step(0, 1, 9'd1, 1, 9'd2);
      check("retain_first_grant0", 32'(req0_ready), 32'd1);
      repeat (3) step(0, 1, 9'd3, 0, 0);
      step(0, 1, 9'd4, 1, 9'd5);
      check("retain_grant1", 32'(req1_ready), 32'd1);
      check("retain_not0", 32'(req0_ready), 32'd0);

      // Reset right after a grant cancels the response; priority restarts at 0.
      step(1, 0, 0, 0, 0);
      step(0, 1, 9'd6, 0, 0);
      check("rstmid_grant0", 32'(req0_ready), 32'd1);
      step(1, 1, 9'd7, 1, 9'd8);
      check("rstmid_rsp0_T1", 32'(rsp0_valid), 32'd0);
      check("rstmid_no_ready_in_rst", 32'(req0_ready | req1_ready), 32'd0);
      step(0, 1, 9'd7, 1, 9'd8);
      check("rstmid_rsp0_T2", 32'(rsp0_valid), 32'd0);
      check("rstmid_grant0_after", 32'(req0_ready), 32'd1);

      // Withdrawal: requester 1 loses once, then drops its request.
      step(1, 0, 0, 0, 0);
      step(0, 1, 9'd10, 1, 9'd9);
      check("wd_grant0", 32'(req0_ready), 32'd1);
      step(0, 1, 9'd11, 0, 0);
      check("wd_no_rsp1_a", 32'(rsp1_valid), 32'd0);
      step(0, 0, 0, 0, 0);
      check("wd_no_rsp1_b", 32'(rsp1_valid), 32'd0);
      step(0, 1, 9'd12, 1, 9'd13);
      check("wd_prio_toggled", 32'(req1_ready), 32'd1);

      // Random traffic: pending requests hold their index, occasional withdrawal and reset.
      h_v0 = 0; h_v1 = 0; h_i0 = '0; h_i1 = '0;
      for (int k = 0; k < 3000; k++) begin
         bit r;
         r = ($urandom_range(63) == 0);
         if (!(h_v0 && last_w != 0) || $urandom_range(7) == 0) begin
            h_v0 = ($urandom_range(3) != 0);
            h_i0 = 9'($urandom);
         end
         if (!(h_v1 && last_w != 1) || $urandom_range(7) == 0) begin
            h_v1 = ($urandom_range(3) != 0);
            h_i1 = 9'($urandom);
         end
         step(r, h_v0, h_i0, h_v1, h_i1);
         check("rand_one_grant", 32'(req0_ready & req1_ready), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
